// File: rtl/fifo_write_arbiter_if.sv
// Bundle of producer handshake and FIFO write-side signals shared by the
// write arbiter and whatever drives it (producers plus FIFO status).
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 4
);
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;
  logic [NUM_REQ-1:0]        grant;
  logic                      fifoWrite;
  logic [DATA_W-1:0]         fifoDataIn;
  logic                      fifoFull;
  logic [COUNT_W-1:0]        fifoCount;
  logic                      overflowErr;

  // Environment side: producers and FIFO status drive, arbiter results observed
  modport master (
    output reqValid, reqData, reqLast, fifoFull, fifoCount,
    input  reqReady, grant, fifoWrite, fifoDataIn, overflowErr
  );

  // Arbiter side
  modport slave (
    input  reqValid, reqData, reqLast, fifoFull, fifoCount,
    output reqReady, grant, fifoWrite, fifoDataIn, overflowErr
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the single write port of a small sync
// FIFO between several producers. Free space is judged from the FIFO count
// plus the write still in flight, so the FIFO is never written while full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int COUNT_W   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clock,
  input  logic               reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COUNT_W:0] DEPTH_V     = (COUNT_W+1)'(DEPTH);
  localparam logic [3:0]       LAST_BEAT   = 4'(MAX_BURST - 1);
  localparam logic [OWNER_W:0] NUM_REQ_V   = (OWNER_W+1)'(NUM_REQ);
  localparam logic [OWNER_W-1:0] LAST_OWNER = OWNER_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               r_state;
  logic [OWNER_W-1:0]   r_rrPtr;
  logic [OWNER_W-1:0]   r_owner;
  logic [3:0]           r_burstCnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_fifoWrite;
  logic [DATA_W-1:0]    r_fifoDataIn;
  logic                 r_overflowErr;

  logic [COUNT_W:0]     w_occupancy;
  logic                 w_spaceOk;
  logic [2*NUM_REQ-1:0] w_reqRotated;
  logic                 w_pickFound;
  logic [OWNER_W-1:0]   w_pickIdx;
  logic [OWNER_W:0]     w_pickSum;
  logic                 w_ownerValid;
  logic                 w_ownerLast;
  logic [DATA_W-1:0]    w_ownerData;
  logic [NUM_REQ-1:0]   w_ownerOneHot;
  logic [OWNER_W-1:0]   w_ownerNext;
  logic                 w_accept;
  logic                 w_release;

  // A write issued last cycle is not yet visible in fifoCount, so count it here.
  assign w_occupancy = {1'b0, bus.fifoCount} + {{COUNT_W{1'b0}}, r_fifoWrite};
  assign w_spaceOk   = !bus.fifoFull && (w_occupancy < DEPTH_V);

  // Rotating the doubled request vector puts rrPtr at bit 0, so the lowest set bit wins.
  assign w_reqRotated = {bus.reqValid, bus.reqValid} >> r_rrPtr;

  assign w_ownerValid  = bus.reqValid[r_owner];
  assign w_ownerLast   = bus.reqLast[r_owner];
  assign w_ownerData   = bus.reqData[r_owner*DATA_W +: DATA_W];
  assign w_ownerOneHot = NUM_REQ'(1) << r_owner;
  assign w_ownerNext   = (r_owner == LAST_OWNER) ? '0 : r_owner + 1'b1;

  assign w_accept  = (r_state == BURST) && w_ownerValid && w_spaceOk;
  assign w_release = (r_state == BURST) &&
                     ((w_accept && (w_ownerLast || (r_burstCnt == LAST_BEAT))) ||
                      (!w_ownerValid && w_spaceOk));

  assign bus.reqReady    = ((r_state == BURST) && w_spaceOk) ? w_ownerOneHot : '0;
  assign bus.grant       = r_grant;
  assign bus.fifoWrite   = r_fifoWrite;
  assign bus.fifoDataIn  = r_fifoDataIn;
  assign bus.overflowErr = r_overflowErr;

  // Pick the first requester at or after rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    w_pickFound = 1'b0;
    w_pickIdx   = '0;
    w_pickSum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_reqRotated[k]) begin
        w_pickFound = 1'b1;
        w_pickSum   = {1'b0, r_rrPtr} + (OWNER_W+1)'(k);
        if (w_pickSum >= NUM_REQ_V) begin
          w_pickSum = w_pickSum - NUM_REQ_V;
        end
        w_pickIdx = w_pickSum[OWNER_W-1:0];
      end
    end
  end

  // Arbitration FSM with registered grant, write strobe, data and error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rrPtr       <= '0;
      r_owner       <= '0;
      r_burstCnt    <= '0;
      r_grant       <= '0;
      r_fifoWrite   <= 1'b0;
      r_fifoDataIn  <= '0;
      r_overflowErr <= 1'b0;
    end else begin
      r_overflowErr <= r_fifoWrite & bus.fifoFull;
      r_fifoWrite   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pickFound) begin
            r_state    <= BURST;
            r_owner    <= w_pickIdx;
            r_grant    <= NUM_REQ'(1) << w_pickIdx;
            r_burstCnt <= '0;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_fifoWrite  <= 1'b1;
            r_fifoDataIn <= w_ownerData;
            r_burstCnt   <= r_burstCnt + 4'd1;
          end
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rrPtr <= w_ownerNext;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end
endmodule
